// File: rtl/fft_pipe_ctrl_pkg.sv
// Shared types and stage-geometry helpers for the radix-2 SDF FFT pipeline controller.
package fft_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Twiddle-multiplier result carried alongside the datapath.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_product_t;

    // Delay-line length of stage s for an n-point transform.
    function automatic int unsigned stage_delay(input int unsigned n, input int unsigned s);
        return n >> (s + 1);
    endfunction

    // Cycles from first accepted sample until it reaches stage s.
    function automatic int unsigned stage_offset(input int unsigned n, input int unsigned s);
        return n - (n >> s);
    endfunction

endpackage

// File: rtl/fft_pipe_ctrl.sv
// Control sequencer for a radix-2 single-delay-feedback FFT pipeline: frame tracking,
// per-stage enables and butterfly selects, and output framing qualifiers.
module fft_pipe_ctrl
    import fft_pipe_ctrl_pkg::*;
#(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned LOG2N    = $clog2(N_POINTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sop,
    output logic             in_ready,
    input  logic             flush,
    output logic [LOG2N-1:0] stage_enable,
    output logic [LOG2N-1:0] bf_sel,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             err,
    output logic             busy
);

    localparam logic [LOG2N-1:0] GLast     = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] GDrainEnd = LOG2N'(N_POINTS - 2);
    localparam logic [LOG2N-1:0] GOne      = LOG2N'(1);

    state_e            state_q, state_d;
    logic [LOG2N-1:0]  g_q, g_d;
    logic [LOG2N-1:0]  en_q, en_d;
    logic [LOG2N-1:0]  bf_q, bf_d;
    logic              ov_q, ov_d;
    logic              os_q, os_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // DRAIN is the only state that refuses input.
    assign in_ready = (state_q != StDrain);

    // Frame sequencing: g is the index of the most recently accepted sample (RUN) or the
    // drain count (DRAIN); framing violations abort to IDLE, flush overrides everything.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_sop) begin
                    state_d = StRun;
                    g_d     = '0;
                end
            end
            StRun: begin
                g_d = g_q + GOne;
                if (g_q == GLast) begin
                    if (!in_valid) begin
                        state_d = StDrain;
                    end else if (!in_sop) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end else if (!in_valid || in_sop) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StDrain: begin
                g_d = g_q + GOne;
                if (g_q == GDrainEnd) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            err_d   = 1'b0;
        end
        if (state_d == StIdle) g_d = '0;
    end

    // Per-stage enable is sticky from the first sample's arrival until IDLE; the select
    // bit is the MSB-side phase of that stage's position within its frame.
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam logic [LOG2N-1:0] Ls = LOG2N'(stage_offset(N_POINTS, s));
        logic [LOG2N-1:0] phase;
        assign phase   = g_d - Ls;
        assign en_d[s] = (state_d != StIdle) && (en_q[s] || (g_d == Ls));
        assign bf_d[s] = en_d[s] && phase[LOG2N-1-s];
    end

    // Output stream starts with the first frame's last sample (latency N-1) and then runs
    // without gaps until the pipeline returns to IDLE.
    always_comb begin
        busy_d = (state_d != StIdle);
        ov_d   = busy_d && (ov_q || ((state_d == StRun) && (g_d == GLast)));
        os_d   = ov_d && (state_d == StRun) && (g_d == GLast);
        oe_d   = ov_d && (g_d == GDrainEnd);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            g_q     <= '0;
            en_q    <= '0;
            bf_q    <= '0;
            ov_q    <= 1'b0;
            os_q    <= 1'b0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            en_q    <= en_d;
            bf_q    <= bf_d;
            ov_q    <= ov_d;
            os_q    <= os_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign stage_enable = en_q;
    assign bf_sel       = bf_q;
    assign out_valid    = ov_q;
    assign out_sop      = os_q;
    assign out_eop      = oe_q;
    assign err          = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Directed bench for fft_pipe_ctrl at N_POINTS=8 (D=4,2,1; L=0,4,6).
module tb_fft_pipe_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned LG = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_sop;
    logic          in_ready;
    logic          flush;
    logic [LG-1:0] stage_enable;
    logic [LG-1:0] bf_sel;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          err;
    logic          busy;

    fft_pipe_ctrl #(.N_POINTS(N), .LOG2N(LG)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_ready     (in_ready),
        .flush        (flush),
        .stage_enable (stage_enable),
        .bf_sel       (bf_sel),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sop;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [16];
    int   n_vec = 0;
    int   n_bad = 0;

    // Packed view: {rdy, busy, err, eop, sop, ov, bf[2:0], en[2:0]}
    logic [11:0] obs;
    assign obs = {in_ready, busy, err, out_eop, out_sop, out_valid, bf_sel, stage_enable};

    function automatic logic [11:0] mk(input logic rdy, input logic bz, input logic er,
                                       input logic oe, input logic os, input logic ov,
                                       input logic [2:0] bf, input logic [2:0] en);
        return {rdy, bz, er, oe, os, ov, bf, en};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    // Present inputs for one clock, then settle just past the edge.
    task automatic step(input logic v, input logic s, input logic f);
        in_valid = v;
        in_sop   = s;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic v, input logic s, input logic [11:0] e);
        tbl[i].v   = v;
        tbl[i].sop = s;
        tbl[i].exp = e;
    endtask

    initial begin
        // Single frame, sop at cycle 0, then drain.
        set_row(0,  1, 1, mk(1, 1, 0, 0, 0, 0, 3'b000, 3'b001));
        set_row(1,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b000, 3'b001));
        set_row(2,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b000, 3'b001));
        set_row(3,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b000, 3'b001));
        set_row(4,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b001, 3'b011));
        set_row(5,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b001, 3'b011));
        set_row(6,  1, 0, mk(1, 1, 0, 0, 0, 0, 3'b011, 3'b111));
        set_row(7,  1, 0, mk(1, 1, 0, 0, 1, 1, 3'b111, 3'b111));
        set_row(8,  0, 0, mk(0, 1, 0, 0, 0, 1, 3'b000, 3'b111));
        set_row(9,  0, 0, mk(0, 1, 0, 0, 0, 1, 3'b100, 3'b111));
        set_row(10, 0, 0, mk(0, 1, 0, 0, 0, 1, 3'b010, 3'b111));
        set_row(11, 0, 0, mk(0, 1, 0, 0, 0, 1, 3'b110, 3'b111));
        set_row(12, 0, 0, mk(0, 1, 0, 0, 0, 1, 3'b001, 3'b111));
        set_row(13, 0, 0, mk(0, 1, 0, 0, 0, 1, 3'b101, 3'b111));
        set_row(14, 0, 0, mk(0, 1, 0, 1, 0, 1, 3'b011, 3'b111));
        set_row(15, 0, 0, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        flush    = 1'b0;
        #1;
        check("reset_state", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("after_release", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Valid without sop in IDLE is dropped silently.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check("idle_nosop", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        end

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].sop, 1'b0);
            check($sformatf("single_c%0d", i), obs, tbl[i].exp);
        end

        // Three back-to-back frames: continuous output, enables never drop.
        for (int c = 0; c < 32; c++) begin
            logic [2:0] en_e;
            logic       ov_e, os_e, oe_e, bz_e;
            step(c < 24, (c % 8 == 0) && (c < 24), 0);
            en_e = (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : (c < 31) ? 3'b111 : 3'b000;
            ov_e = (c >= 7) && (c <= 30);
            os_e = (c == 7) || (c == 15) || (c == 23);
            oe_e = (c == 14) || (c == 22) || (c == 30);
            bz_e = (c < 31);
            check($sformatf("b2b_c%0d", c), {4'b0, bz_e, err, oe_e, os_e, ov_e, en_e},
                  {4'b0, busy, 1'b0, out_eop, out_sop, out_valid, stage_enable});
        end

        // in_valid drops mid-frame at g=3.
        step(1, 1, 0);
        for (int i = 1; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
        check("gap_err", obs, mk(1, 0, 1, 0, 0, 0, 3'b000, 3'b000));
        step(0, 0, 0);
        check("gap_err_clear", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        // sop in the middle of a frame.
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        check("midsop_err", obs, mk(1, 0, 1, 0, 0, 0, 3'b000, 3'b000));

        // Valid without sop right after a frame boundary.
        step(1, 1, 0);
        for (int i = 1; i < 8; i++) step(1, 0, 0);
        step(1, 0, 0);
        check("boundary_err", obs, mk(1, 0, 1, 0, 0, 0, 3'b000, 3'b000));

        // Flush coinciding with a violation suppresses err.
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check("flush_over_err", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Flush at cycle 10 of a single frame, new sop at cycle 11.
        step(1, 1, 0);
        for (int i = 1; i < 8; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pre_flush_c9", obs, mk(0, 1, 0, 0, 0, 1, 3'b100, 3'b111));
        step(0, 0, 1);
        check("flush_c10", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        step(1, 1, 0);
        check("sop_after_flush", obs, mk(1, 1, 0, 0, 0, 0, 3'b000, 3'b001));
        step(0, 0, 1);

        // Asynchronous reset mid-frame at cycle 5.
        step(1, 1, 0);
        for (int i = 1; i < 5; i++) step(1, 0, 0);
        in_valid = 1'b1;
        in_sop   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {1'b0, obs[10:0]}, 12'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_release_rdy", obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            check($sformatf("post_reset_%0d", i), obs, mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
